// File: rtl/aud_codec_tx.sv
// I2S-style stereo serializer: divides i_clk into BCLK, frames 16-bit left/right
// samples MSB first one BCLK after each LRCK edge, fed from a one-deep holding buffer.
module aud_codec_tx #(
  parameter int CLK_DIV   = 4,
  parameter int SLOT_BITS = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_valid,
  input  logic [15:0] i_left,
  input  logic [15:0] i_right,
  output logic        o_ready,
  output logic        o_bclk,
  output logic        o_lrck,
  output logic        o_dat,
  output logic        o_frame_start,
  output logic        o_underrun
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [6:0] BIT_LAST = 7'(2 * SLOT_BITS - 1);
  localparam logic [6:0] SLOT     = 7'(SLOT_BITS);

  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [6:0]  bit_cnt_q, bit_cnt_d;
  logic        bclk_q, bclk_d;
  logic        lrck_q, lrck_d;
  logic        dat_q, dat_d;
  logic        hold_full_q, hold_full_d;
  logic [15:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [15:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic        ready_q, ready_d;
  logic        fs_q, fs_d;
  logic        un_q, un_d;

  logic        accept, tc, fall, frame_evt, left_nxt;
  logic [6:0]  bit_nxt, slot_pos;

  always_comb begin
    accept    = i_valid & ready_q;
    tc        = (div_cnt_q == DIV_LAST);
    fall      = i_en & tc & bclk_q;
    frame_evt = fall & (bit_cnt_q == BIT_LAST);
    bit_nxt   = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 7'd1;
    left_nxt  = (bit_nxt < SLOT);
    slot_pos  = left_nxt ? bit_nxt : bit_nxt - SLOT;

    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    bclk_d    = bclk_q;
    lrck_d    = lrck_q;
    dat_d     = dat_q;
    sh_l_d    = sh_l_q;
    sh_r_d    = sh_r_q;
    fs_d      = 1'b0;
    un_d      = 1'b0;

    if (!i_en) begin
      div_cnt_d = '0;
      bit_cnt_d = BIT_LAST;
      bclk_d    = 1'b0;
      lrck_d    = 1'b0;
      dat_d     = 1'b0;
      sh_l_d    = '0;
      sh_r_d    = '0;
    end else begin
      div_cnt_d = tc ? '0 : div_cnt_q + 8'd1;
      if (tc) bclk_d = ~bclk_q;
      if (fall) begin
        bit_cnt_d = bit_nxt;
        lrck_d    = left_nxt;
        dat_d     = 1'b0;
        if (frame_evt) begin
          fs_d   = 1'b1;
          un_d   = ~hold_full_q;
          sh_l_d = hold_full_q ? hold_l_q : '0;
          sh_r_d = hold_full_q ? hold_r_q : '0;
        end else if (slot_pos >= 7'd1 && slot_pos <= 7'd16) begin
          // Slot position 0 is the one-BCLK gap after the LRCK edge; then 16 bits MSB first.
          if (left_nxt) begin
            dat_d  = sh_l_q[15];
            sh_l_d = {sh_l_q[14:0], 1'b0};
          end else begin
            dat_d  = sh_r_q[15];
            sh_r_d = {sh_r_q[14:0], 1'b0};
          end
        end
      end
    end
  end

  always_comb begin
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    if (frame_evt && hold_full_q) hold_full_d = 1'b0;
    if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = i_left;
      hold_r_d    = i_right;
    end
    // Empty is advertised the cycle after the frame-start pulse, full the cycle after an accept.
    ready_d = ~hold_full_q & ~accept;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_cnt_q   <= '0;
      bit_cnt_q   <= BIT_LAST;
      bclk_q      <= 1'b0;
      lrck_q      <= 1'b0;
      dat_q       <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      sh_l_q      <= '0;
      sh_r_q      <= '0;
      ready_q     <= 1'b1;
      fs_q        <= 1'b0;
      un_q        <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      bclk_q      <= bclk_d;
      lrck_q      <= lrck_d;
      dat_q       <= dat_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      sh_l_q      <= sh_l_d;
      sh_r_q      <= sh_r_d;
      ready_q     <= ready_d;
      fs_q        <= fs_d;
      un_q        <= un_d;
    end
  end

  assign o_ready       = ready_q;
  assign o_bclk        = bclk_q;
  assign o_lrck        = lrck_q;
  assign o_dat         = dat_q;
  assign o_frame_start = fs_q;
  assign o_underrun    = un_q;

endmodule

// File: tb/tb_aud_codec_tx.sv
// Randomized bench for aud_codec_tx: a timeline model (cycles since enable) plus a
// one-entry buffer model predicts every output each cycle; literal checks pin the model.
module tb_aud_codec_tx;
  localparam int D = 4;
  localparam int S = 32;
  localparam int FRAME = 2 * S * 2 * D;

  logic clk = 1'b0, rst_n = 1'b1, en = 1'b0, valid = 1'b0;
  logic [15:0] l_in = '0, r_in = '0;
  logic o_ready, o_bclk, o_lrck, o_dat, o_frame_start, o_underrun;

  aud_codec_tx #(.CLK_DIV(D), .SLOT_BITS(S)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_valid(valid),
    .i_left(l_in), .i_right(r_in), .o_ready(o_ready), .o_bclk(o_bclk),
    .o_lrck(o_lrck), .o_dat(o_dat), .o_frame_start(o_frame_start),
    .o_underrun(o_underrun));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t: got timeout expected event", name, $time);
  endtask

  // Model: m_p = cycles since the enable run began (0 while idle).
  int m_p = 0, m_since_fs = 0, m_gap = 0;
  bit m_full = 0, m_ready = 1, m_fs = 0, m_un = 0, m_latched = 0, m_acc_last = 0;
  logic [15:0] m_hl = '0, m_hr = '0, m_fl = '0, m_fr = '0;
  bit acc_w;
  int pn, kk;

  function automatic int bitcnt(input int p);
    return ((p / (2 * D)) + 2 * S - 1) % (2 * S);
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_p = 0; m_full = 0; m_ready = 1; m_fs = 0; m_un = 0; m_latched = 0;
      m_acc_last = 0; m_fl = '0; m_fr = '0; m_since_fs = 0;
    end else begin
      acc_w = valid && m_ready;
      if (acc_w) m_gap = m_since_fs;
      pn = en ? m_p + 1 : 0;
      kk = pn / (2 * D);
      m_fs = (pn > 0) && (pn % (2 * D) == 0) && ((kk - 1) % (2 * S) == 0);
      m_un = 0;
      m_latched = 0;
      if (m_fs) begin
        m_un = !m_full;
        m_latched = m_full;
        m_fl = m_full ? m_hl : 16'h0000;
        m_fr = m_full ? m_hr : 16'h0000;
        m_full = 0;
        m_since_fs = 0;
      end else begin
        m_since_fs++;
      end
      if (acc_w) begin
        m_full = 1;
        m_hl = l_in;
        m_hr = r_in;
      end
      m_acc_last = acc_w;
      m_ready = !m_full && !(m_fs && m_latched);
      m_p = pn;
    end
  end

  int e_bc, e_b, e_bclk, e_lrck, e_dat;
  initial forever begin
    @(negedge clk);
    e_bc   = bitcnt(m_p);
    e_lrck = (e_bc < S) ? 1 : 0;
    e_b    = e_bc % S;
    e_bclk = (m_p / D) % 2;
    e_dat  = (e_b >= 1 && e_b <= 16) ? int'(e_lrck != 0 ? m_fl[16 - e_b] : m_fr[16 - e_b]) : 0;
    chk("bclk",        32'(o_bclk),        32'(e_bclk));
    chk("lrck",        32'(o_lrck),        32'(e_lrck));
    chk("dat",         32'(o_dat),         32'(e_dat));
    chk("ready",       32'(o_ready),       32'(m_ready));
    chk("frame_start", 32'(o_frame_start), 32'(m_fs));
    chk("underrun",    32'(o_underrun),    32'(m_un));
  end

  task automatic capture_frame(output int waited, output logic [15:0] wl, output logic [15:0] wr,
                               output logic un);
    int b;
    waited = 0;
    wl = '0;
    wr = '0;
    @(negedge clk);
    while (!o_frame_start && waited < 3000) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 3000) timeout_fail("frame_start_wait");
    un = o_underrun;
    for (int j = 1; j < FRAME; j++) begin
      @(negedge clk);
      if (j % (2 * D) == D) begin
        b = j / (2 * D);
        if (b >= 1 && b <= 16) wl[16 - b] = o_dat;
        else if (b >= S + 1 && b <= S + 16) wr[S + 16 - b] = o_dat;
      end
    end
  endtask

  task automatic push_sample(input logic [15:0] l, input logic [15:0] r);
    int n;
    valid = 1'b1;
    l_in = l;
    r_in = r;
    for (n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (m_acc_last) break;
    end
    valid = 1'b0;
    if (n >= 3000) timeout_fail("accept_wait");
  endtask

  task automatic wait_full_bitcnt(input int target);
    int n;
    for (n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (m_full && bitcnt(m_p) == target) break;
    end
    if (n >= 3000) timeout_fail("bitcnt_wait");
  endtask

  int waited, n, nacc;
  logic [15:0] wl, wr, sl, sr, cnt;
  logic un;

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bclk",  32'(o_bclk), 32'd0);
    chk("rst_lrck",  32'(o_lrck), 32'd0);
    chk("rst_dat",   32'(o_dat), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_fs",    32'(o_frame_start), 32'd0);
    chk("rst_un",    32'(o_underrun), 32'd0);
    rst_n = 1'b1;

    // Basic frame
    @(posedge clk); #1;
    en = 1'b1; valid = 1'b1; l_in = 16'h8001; r_in = 16'h7FFE;
    fork begin @(posedge clk); #1; valid = 1'b0; end join_none
    capture_frame(waited, wl, wr, un);
    chk("first_fs_cycle", 32'(waited), 32'd8);
    chk("basic_left",  32'(wl), 32'h8001);
    chk("basic_right", 32'(wr), 32'h7FFE);
    chk("basic_no_underrun", 32'(un), 32'd0);

    // Underrun period
    n = 0;
    while (!o_underrun && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) timeout_fail("underrun_wait");
    chk("underrun_is_fs", 32'(o_frame_start), 32'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (!o_underrun && n < 2000);
    chk("underrun_period", 32'(n), 32'd512);

    // Back-pressure with incrementing data
    cnt = 16'h0100; nacc = 0;
    valid = 1'b1; l_in = cnt; r_in = ~cnt;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(posedge clk); #1;
      if (m_acc_last) begin
        nacc++;
        if (nacc > 1) chk("accept_after_fs", 32'(m_gap), 32'd1);
        cnt = cnt + 16'd1;
        l_in = cnt; r_in = ~cnt;
      end
    end
    valid = 1'b0;
    chk("accept_count", 32'(nacc >= 3), 32'd1);

    // Accept in the frame-start cycle of an underrunning frame
    for (n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (m_fs && m_un) break;
    end
    if (n >= 3000) timeout_fail("empty_fs_wait");
    sl = 16'($urandom); sr = 16'($urandom);
    valid = 1'b1; l_in = sl; r_in = sr;
    fork begin @(posedge clk); #1; valid = 1'b0; end join_none
    @(negedge clk);
    chk("simul_underrun", 32'(o_underrun), 32'd1);
    chk("simul_ready", 32'(o_ready), 32'd1);
    capture_frame(waited, wl, wr, un);
    chk("simul_next_left", 32'(wl), 32'(sl));
    chk("simul_next_right", 32'(wr), 32'(sr));
    chk("simul_next_un", 32'(un), 32'd0);

    // Mid-frame disable then re-enable
    sl = 16'($urandom); sr = 16'($urandom);
    push_sample(sl, sr);
    wait_full_bitcnt(10);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("dis_bclk", 32'(o_bclk), 32'd0);
    chk("dis_lrck", 32'(o_lrck), 32'd0);
    chk("dis_dat",  32'(o_dat), 32'd0);
    chk("dis_ready", 32'(o_ready), 32'd0);
    repeat (5) @(posedge clk);
    #1 en = 1'b1;
    capture_frame(waited, wl, wr, un);
    chk("reen_fs_cycle", 32'(waited), 32'd8);
    chk("reen_left", 32'(wl), 32'(sl));
    chk("reen_right", 32'(wr), 32'(sr));

    // Asynchronous reset mid-frame with buffer full
    push_sample(16'($urandom), 16'($urandom));
    wait_full_bitcnt(40);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bclk",  32'(o_bclk), 32'd0);
    chk("arst_lrck",  32'(o_lrck), 32'd0);
    chk("arst_dat",   32'(o_dat), 32'd0);
    chk("arst_ready", 32'(o_ready), 32'd1);
    chk("arst_fs",    32'(o_frame_start), 32'd0);
    chk("arst_un",    32'(o_underrun), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Random traffic with occasional enable toggles
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      valid = ($urandom_range(0, 99) < 2);
      l_in = 16'($urandom);
      r_in = 16'($urandom);
      if ($urandom_range(0, 999) == 0) en = ~en;
    end
    valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got %0t expected finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/aud_codec_tx.md
AUD_CODEC_TX -- requirements
Module: aud_codec_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: i_clk cycles per BCLK half-period, legal values 2 to 255.
REQ-002 SHALL have parameter SLOT_BITS, default 32: BCLK periods per channel slot, legal values 16 to 64.
REQ-003 SHALL have port i_clk, input, 1 bit: sole clock; every flop is clocked on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_en, input, 1 bit: serializer run enable.
REQ-006 SHALL have port i_valid, input, 1 bit: a stereo sample is offered.
REQ-007 SHALL have port i_left, input, 16 bits: signed left sample.
REQ-008 SHALL have port i_right, input, 16 bits: signed right sample.
REQ-009 SHALL have port o_ready, output, 1 bit: holding buffer empty, so a sample can be accepted.
REQ-010 SHALL have port o_bclk, output, 1 bit: generated bit clock.
REQ-011 SHALL have port o_lrck, output, 1 bit: frame clock; 1 = left slot, 0 = right slot.
REQ-012 SHALL have port o_dat, output, 1 bit: serial data, MSB first.
REQ-013 SHALL have port o_frame_start, output, 1 bit: one-cycle pulse on each frame start.
REQ-014 SHALL have port o_underrun, output, 1 bit: one-cycle pulse when a frame starts with the holding buffer empty.

Function
REQ-015 A sample SHALL be accepted only in a cycle with i_valid=1 and o_ready=1; {i_left,i_right} is written to the holding buffer and o_ready goes 0 the next cycle.
REQ-016 o_ready SHALL be a registered value equal to NOT(holding buffer full).
REQ-017 Divider: while i_en=1, div_cnt SHALL count 0..CLK_DIV-1; at terminal count it wraps to 0 and o_bclk toggles in the same cycle.
REQ-018 Falling BCLK event: a cycle in which o_bclk toggles 1 to 0; bit_cnt SHALL advance by 1 modulo 2*SLOT_BITS on each such event.
REQ-019 Frame start: the falling BCLK event on which bit_cnt wraps to 0.
REQ-020 o_lrck SHALL be 1 while bit_cnt < SLOT_BITS and 0 otherwise; it changes only on falling BCLK events.
REQ-021 o_dat SHALL carry sample bit (16-b) for slot position b = 1..16, where b = bit_cnt mod SLOT_BITS; it is 0 for b = 0 and for b > 16. This gives a one-BCLK delay after the LRCK edge, MSB first.
REQ-022 o_dat SHALL change only on falling BCLK events, so the receiver samples it on the rising BCLK.
REQ-023 The left slot SHALL carry the latched left sample and the right slot the latched right sample.
REQ-024 On frame start with the holding buffer full, the block SHALL latch the holding buffer into the left/right shift registers and empty the holding buffer; o_ready becomes 1 the next cycle.
REQ-025 On frame start with the holding buffer empty, both channels of that frame SHALL transmit 0x0000 and o_underrun SHALL pulse for exactly the frame-start cycle.
REQ-026 o_frame_start SHALL pulse 1 for exactly the frame-start cycle.
REQ-027 Simultaneous events: an accept in the frame-start cycle of an empty-buffer frame SHALL fill the holding buffer for the next frame only; that frame still underruns (REQ-025).
REQ-028 A latched frame SHALL be transmitted in full; the holding buffer has no effect on a frame after its frame start.
REQ-029 While i_en=0: the block SHALL hold o_bclk=0, o_lrck=0, o_dat=0, div_cnt=0 and bit_cnt=2*SLOT_BITS-1, and SHALL clear the shift registers.
REQ-030 While i_en=0 the holding buffer and the accept handshake SHALL keep operating.
REQ-031 i_en falling mid-frame SHALL force the idle state of REQ-029 on the next cycle; the partial frame is abandoned.
REQ-032 From idle with i_en=1: o_bclk SHALL rise CLK_DIV cycles later and fall 2*CLK_DIV cycles later, and that fall is a frame start.

Reset
REQ-033 While i_rst_n=0, outputs SHALL be o_bclk=0, o_lrck=0, o_dat=0, o_ready=1, o_frame_start=0, o_underrun=0.
REQ-034 While i_rst_n=0, internal state SHALL be div_cnt=0, bit_cnt=2*SLOT_BITS-1, holding buffer empty, shift registers 0.
REQ-035 Reset asserted mid-operation SHALL reach the REQ-033/REQ-034 state immediately (asynchronously), discarding any buffered sample.

Verification
REQ-036 Basic frame (CLK_DIV=4, SLOT_BITS=32): reset, i_en=1, one accept L=0x8001 R=0x7FFE -> frame start at cycle 8; o_lrck=1 for 32 BCLK; left slot bits 1..16 = 1000000000000001; right slot bits 1..16 = 0111111111111110; all other bits 0; o_bclk period 8 cycles.
REQ-037 Underrun: i_en=1 with no accepts -> o_underrun and o_frame_start pulse every 512 cycles; o_dat constant 0.
REQ-038 Back-pressure: hold i_valid=1 with incrementing data -> exactly one accept per frame, each accept in the cycle after a frame start; no sample lost or duplicated.
REQ-039 Simultaneous accept at an empty-buffer frame start -> o_underrun pulses; the sample appears in the following frame.
REQ-040 Mid-frame disable: drop i_en at bit_cnt=10 -> next cycle o_bclk=0, o_lrck=0, o_dat=0.
REQ-041 Re-enable after mid-frame disable -> new frame start after 8 cycles, transmitting the still-buffered sample.
REQ-042 Asynchronous reset at bit_cnt=40 with the buffer full -> outputs reach the REQ-033 values without waiting for a clock edge; o_ready=1.
